// File: rtl/fetch_queue.sv
// Instruction-fetch queue between the PC register and decode.
// Issues in-order word fetches, buffers tagged results, and flushes on redirect.
module fetch_queue #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] pc_i,
  output logic               pc_advance_o,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [D_WIDTH-1:0] imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [D_WIDTH-1:0] imem_rsp_data_i,
  input  logic               redirect_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [D_WIDTH-1:0] dec_instr_o,
  output logic [D_WIDTH-1:0] dec_pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [D_WIDTH-1:0] pc_q    [DEPTH];
  logic [D_WIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]   filled_q;

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] kill_q, kill_d;
  // Allocated entries still waiting for their response.
  logic [CW-1:0] pend_q, pend_d;

  logic          req_hs;
  logic          deq_hs;
  logic          rsp_fire;
  logic          rsp_kill;
  logic          rsp_fill;
  logic          has_entries;
  logic [CW:0]   occ;
  logic [CW-1:0] flush_sum;
  logic          flush_drop;

  assign occ              = {1'b0, count_q} + {1'b0, kill_q};
  assign imem_req_valid_o = !rst && !redirect_i && (occ < DEPTH_C);
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign pc_advance_o     = req_hs;
  assign imem_req_addr_o  = pc_i;

  assign has_entries = !rst && (count_q != '0);
  assign dec_valid_o = has_entries && filled_q[head_ptr_q] && !redirect_i;
  assign dec_instr_o = has_entries ? instr_q[head_ptr_q] : '0;
  assign dec_pc_o    = has_entries ? pc_q[head_ptr_q] : '0;
  assign deq_hs      = dec_valid_o && dec_ready_i;

  // Stray responses with nothing outstanding fall through both terms and are ignored.
  assign rsp_fire = imem_rsp_valid_i && !rst;
  assign rsp_kill = rsp_fire && (kill_q != '0);
  assign rsp_fill = rsp_fire && (kill_q == '0) && (pend_q != '0) && !redirect_i;

  assign flush_sum  = pend_q + kill_q;
  assign flush_drop = rsp_fire && (flush_sum != '0);

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    if (redirect_i) begin
      // Every unfilled entry becomes a response to drop; one arriving now is dropped on the spot.
      count_d    = '0;
      pend_d     = '0;
      fill_ptr_d = alloc_ptr_q;
      head_ptr_d = alloc_ptr_q;
      kill_d     = flush_sum - CW'(flush_drop);
    end else begin
      if (rsp_kill) kill_d = kill_q - CW'(1);
      if (rsp_fill) fill_ptr_d = fill_ptr_q + PW'(1);
      if (req_hs) alloc_ptr_d = alloc_ptr_q + PW'(1);
      if (deq_hs) head_ptr_d = head_ptr_q + PW'(1);
      pend_d  = pend_q + CW'(req_hs) - CW'(rsp_fill);
      count_d = count_q + CW'(req_hs) - CW'(deq_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      kill_q      <= '0;
      pend_q      <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      kill_q      <= kill_d;
      pend_q      <= pend_d;
      // Alloc and fill never target the same slot: that would need DEPTH pending entries.
      if (req_hs) filled_q[alloc_ptr_q] <= 1'b0;
      if (rsp_fill) filled_q[fill_ptr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) pc_q[alloc_ptr_q] <= pc_i;
    if (rsp_fill) instr_q[fill_ptr_q] <= imem_rsp_data_i;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC register and in-order memory models, a decode
// scoreboard, a cycle table, directed redirect/reset sequences and a random run.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pc_i;
  logic          pc_advance_o;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i;
  logic [DW-1:0] imem_req_addr_o;
  logic          imem_rsp_valid_i;
  logic [DW-1:0] imem_rsp_data_i;
  logic          redirect_i;
  logic          dec_valid_o;
  logic          dec_ready_i;
  logic [DW-1:0] dec_instr_o;
  logic [DW-1:0] dec_pc_o;

  always #5 clk = ~clk;

  fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .pc_advance_o     (pc_advance_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_instr_o      (dec_instr_o),
    .dec_pc_o         (dec_pc_o)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } dec_t;
  typedef struct { bit dr; bit mr; bit rv; bit dv; bit chk_pc; logic [31:0] pc; } vec_t;

  mreq_t inflight[$];
  dec_t  exp_q[$];
  vec_t  tbl[19];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat_fix  = 1;
  bit lat_rand = 0;
  logic [31:0] pc_reg = '0;
  logic [31:0] redir_target = '0;

  bit s_rst, s_redirect, s_req_valid, s_adv, s_req_hs, s_rsp, s_dec_valid, s_dec_hs;
  logic [31:0] s_addr, s_dec_pc, s_dec_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Sample everything mid-cycle, after inputs have settled.
  task automatic half();
    @(negedge clk);
    assert (!(imem_rsp_valid_i && inflight.size() == 0))
      else $error("memory model produced a response with nothing outstanding");
    s_rst       = rst;
    s_redirect  = redirect_i;
    s_req_valid = imem_req_valid_o;
    s_adv       = pc_advance_o;
    s_req_hs    = imem_req_valid_o && imem_req_ready_i;
    s_addr      = imem_req_addr_o;
    s_rsp       = imem_rsp_valid_i;
    s_dec_valid = dec_valid_o;
    s_dec_hs    = dec_valid_o && dec_ready_i;
    s_dec_pc    = dec_pc_o;
    s_dec_instr = dec_instr_o;
  endtask

  // Scoreboard compare, then clock edge, then PC register and memory model update.
  task automatic tick();
    dec_t  d;
    mreq_t m;
    int    lat;
    if (!s_rst) begin
      chk("outstanding_bound", 32'(inflight.size() <= DEPTH), 32'd1);
      chk("pc_advance_vs_hs", 32'(s_adv), 32'(s_req_hs));
      if (s_redirect) begin
        chk("redirect_req_valid", 32'(s_req_valid), 32'd0);
        chk("redirect_dec_valid", 32'(s_dec_valid), 32'd0);
        exp_q.delete();
      end else begin
        if (s_dec_hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_decode actual_pc=0x%08h required=none cycle=%0d", s_dec_pc, cyc);
          end else begin
            d = exp_q.pop_front();
            chk("sb_pc", s_dec_pc, d.pc);
            chk("sb_instr", s_dec_instr, d.instr);
          end
        end
        if (s_req_hs) begin
          chk("req_addr", s_addr, pc_reg);
          d.pc    = pc_reg;
          d.instr = instr_of(pc_reg);
          exp_q.push_back(d);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      inflight.delete();
      exp_q.delete();
      pc_reg = '0;
    end else begin
      if (s_rsp) m = inflight.pop_front();
      if (s_req_hs) begin
        lat    = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
        m.addr = s_addr;
        m.due  = cyc - 1 + lat;
        if (inflight.size() > 0 && m.due <= inflight[$].due) m.due = inflight[$].due + 1;
        inflight.push_back(m);
      end
      if (s_redirect) pc_reg = redir_target;
      else if (s_adv) pc_reg = pc_reg + 32'd4;
    end
    pc_i = pc_reg;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = instr_of(inflight[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
  endtask

  task automatic step();
    half();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_dec(input logic [31:0] exp_pc, input string nm);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      half();
      if (dec_valid_o) begin
        found = 1;
        chk({nm, "_pc"}, dec_pc_o, exp_pc);
        chk({nm, "_instr"}, dec_instr_o, instr_of(exp_pc));
      end
      tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_decode required_pc=0x%08h cycle=%0d", nm, exp_pc, cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          dr    mr    rv    dv    chk   pc
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0C};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h14};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h18};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1C};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h24};

    rst = 1'b1;
    pc_i = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    redirect_i = 1'b0;
    dec_ready_i = 1'b0;

    // Fill to DEPTH with decode stalled, drain, then stall memory and restart.
    do_reset();
    lat_fix = 1;
    foreach (tbl[i]) begin
      dec_ready_i = tbl[i].dr;
      imem_req_ready_i = tbl[i].mr;
      half();
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid_o), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_pc_advance", i), 32'(pc_advance_o), 32'(tbl[i].rv & tbl[i].mr));
      chk($sformatf("tbl%0d_dec_valid", i), 32'(dec_valid_o), 32'(tbl[i].dv));
      if (tbl[i].chk_pc) begin
        chk($sformatf("tbl%0d_dec_pc", i), dec_pc_o, tbl[i].pc);
        chk($sformatf("tbl%0d_dec_instr", i), dec_instr_o, tbl[i].dv ? instr_of(tbl[i].pc) : 32'h0);
      end
      tick();
    end

    // Three slow fetches outstanding, then redirect to 0x100.
    do_reset();
    lat_fix = 5;
    dec_ready_i = 1'b1;
    imem_req_ready_i = 1'b1;
    repeat (3) step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redir_target = 32'h100;
    half();
    chk("A_redirect_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("A_redirect_advance", 32'(pc_advance_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    half();
    chk("A_req_after_redirect", 32'(imem_req_valid_o), 32'd1);
    chk("A_addr_after_redirect", imem_req_addr_o, 32'h100);
    tick();
    half();
    chk("A_throttle_with_kills", 32'(imem_req_valid_o), 32'd0);
    tick();
    wait_dec(32'h100, "A_first_decode");

    // Full queue, redirect in the same cycle as a response.
    do_reset();
    lat_fix = 1;
    dec_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (4) step();
    redirect_i = 1'b1;
    redir_target = 32'h200;
    half();
    chk("B_redirect_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("B_redirect_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("B_redirect_advance", 32'(pc_advance_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    half();
    chk("B_empty_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("B_empty_dec_pc", dec_pc_o, 32'h0);
    chk("B_empty_dec_instr", dec_instr_o, 32'h0);
    chk("B_req_resume", 32'(imem_req_valid_o), 32'd1);
    tick();
    dec_ready_i = 1'b1;
    wait_dec(32'h200, "B_first_decode");

    // Reset with two entries queued and one fetch in flight.
    do_reset();
    lat_fix = 1;
    dec_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (3) step();
    imem_req_ready_i = 1'b0;
    rst = 1'b1;
    half();
    chk("C_rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("C_rst_dec_valid", 32'(dec_valid_o), 32'd0);
    tick();
    half();
    chk("C_rst2_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("C_rst2_advance", 32'(pc_advance_o), 32'd0);
    chk("C_rst2_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("C_rst2_dec_pc", dec_pc_o, 32'h0);
    chk("C_rst2_dec_instr", dec_instr_o, 32'h0);
    chk("C_rst2_addr", imem_req_addr_o, 32'h0);
    tick();
    rst = 1'b0;
    imem_req_ready_i = 1'b1;
    half();
    chk("C_restart_req_valid", 32'(imem_req_valid_o), 32'd1);
    chk("C_restart_addr", imem_req_addr_o, 32'h0);
    tick();
    dec_ready_i = 1'b1;
    wait_dec(32'h0, "C_first_decode");

    // Random ready, latency and redirects against the scoreboard.
    do_reset();
    lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      dec_ready_i = ($urandom_range(0, 2) != 0);
      redirect_i = ($urandom_range(0, 24) == 0);
      redir_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      step();
    end
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b1;
    repeat (40) step();
    chk("R_drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("R_drain_memory_idle", 32'(inflight.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
